// File: rtl/btop_pkg.sv
// Shared constants, FSM state type and address-step helper for the beta-top
// partial-sum RAM read path of the SCAN polar decoder.
package btop_pkg;

   localparam int N      = 1024;
   localparam int P      = 64;
   localparam int Q      = 6;
   localparam int NCHUNK = 8;
   localparam int CNT_W  = 4;
   localparam int DATA_W = P * Q;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Next chunk index modulo NCHUNK, stepping down when dec is set.
   function automatic logic [CNT_W-1:0] addr_step(input logic [CNT_W-1:0] a,
                                                  input logic             dec);
      logic [CNT_W-1:0] r;
      if (dec) begin
         r = (a == '0) ? CNT_W'(NCHUNK - 1) : a - 1'b1;
      end else begin
         r = (a == CNT_W'(NCHUNK - 1)) ? '0 : a + 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/btop_rd_fifo.sv
// Two-entry registered-output FIFO for captured RAM chunks.
// The head register drives dout directly; the parent guarantees that push
// never occurs when full and pop never occurs when empty.
module btop_rd_fifo
   import btop_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;
   logic [1:0]        count_q, count_d;

   // Next head/tail/count for push, pop, or both at once (order preserved).
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = din;
            else                 tail_d = din;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd2) begin
               head_d = tail_q;
               tail_d = din;
            end else begin
               head_d = din;
            end
         end
         default: ;
      endcase
   end

   // Head and occupancy registers; head clears so dout reads zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         count_q <= count_d;
      end
   end

   // Second slot holds data only; its content is ignored while count < 2.
   always_ff @(posedge clk) begin
      tail_q <= tail_d;
   end

   assign dout  = head_q;
   assign valid = (count_q != 2'd0);
   assign count = count_q;

endmodule

// File: rtl/btop_rd_stream.sv
// Read-side sequencer for the beta-top partial-sum RAM.
// Issues a burst of chunk reads, captures the RAM data one cycle later into a
// 2-entry FIFO and streams it out over valid/ready with full backpressure.
// Optional feature: define BTOP_RD_REVERSE_EN to add the rev input, which makes
// the chunk address step downwards instead of upwards.
module btop_rd_stream
   import btop_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  base,
   input  logic [CNT_W-1:0]  len,
`ifdef BTOP_RD_REVERSE_EN
   input  logic              rev,
`endif
   output logic              busy,
   output logic              done,
   output logic              r_en,
   output logic [CNT_W-1:0]  cntb,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0] issue_left_q, issue_left_d;
   logic [CNT_W-1:0] beats_left_q, beats_left_d;
   logic             pend_q, pend_d;
   logic             done_q, done_d;
   logic             r_en_c;
   logic             hs;
   logic             dec;
   logic [1:0]       fifo_count;
   logic [2:0]       occ;

`ifdef BTOP_RD_REVERSE_EN
   logic             rev_q, rev_d;
   assign dec = rev_q;
`else
   assign dec = 1'b0;
`endif

   assign hs = m_valid && m_ready;

   // Chunks held or in flight once this cycle's pop leaves; a new read is
   // allowed only while that leaves room for its data next cycle.
   assign occ = {1'b0, fifo_count} - {2'b00, hs} + {2'b00, pend_q};

   // FSM next state, burst counters and read issue.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      issue_left_d = issue_left_q;
      beats_left_d = beats_left_q;
      done_d       = 1'b0;
      r_en_c       = 1'b0;
`ifdef BTOP_RD_REVERSE_EN
      rev_d        = rev_q;
`endif
      if (hs) beats_left_d = beats_left_q - 1'b1;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d      = RUN;
                  addr_d       = base;
                  issue_left_d = len;
                  beats_left_d = len;
`ifdef BTOP_RD_REVERSE_EN
                  rev_d        = rev;
`endif
               end
            end
         end
         RUN: begin
            if ((issue_left_q != '0) && (occ < 3'd2)) begin
               r_en_c       = 1'b1;
               addr_d       = addr_step(addr_q, dec);
               issue_left_d = issue_left_q - 1'b1;
               if (issue_left_q == CNT_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (hs && (beats_left_q == CNT_W'(1))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      pend_d = r_en_c;
   end

   // Control registers; reset abandons any burst and drops the in-flight beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         issue_left_q <= '0;
         beats_left_q <= '0;
         pend_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         issue_left_q <= issue_left_d;
         beats_left_q <= beats_left_d;
         pend_q       <= pend_d;
         done_q       <= done_d;
      end
   end

`ifdef BTOP_RD_REVERSE_EN
   // Address direction for the current burst, captured at start.
   always_ff @(posedge clk) begin
      if (rst) rev_q <= 1'b0;
      else     rev_q <= rev_d;
   end
`endif

   btop_rd_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pend_q),
      .pop   (hs),
      .din   (ram_dout),
      .dout  (m_data),
      .valid (m_valid),
      .count (fifo_count)
   );

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign r_en   = r_en_c;
   assign cntb   = addr_q;
   assign m_last = m_valid && (beats_left_q == CNT_W'(1));

endmodule

// File: tb/tb_btop_rd_stream.sv
// Scoreboard bench for btop_rd_stream: bursts push expected addresses and
// beats into queues; a negedge monitor pops and compares as the DUT acts.
module tb_btop_rd_stream;
   import btop_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CNT_W-1:0]  base;
   logic [CNT_W-1:0]  len;
   logic              rev;
   logic              busy, done, r_en, m_valid, m_ready, m_last;
   logic [CNT_W-1:0]  cntb;
   logic [DATA_W-1:0] ram_dout;
   logic [DATA_W-1:0] m_data;

   logic [DATA_W-1:0] ram [NCHUNK];

   logic [CNT_W-1:0]  exp_addr [$];
   logic [DATA_W-1:0] exp_data [$];
   bit                exp_last [$];

   int total = 0;
   int bad   = 0;
   int issued = 0;
   int acc    = 0;
   int done_cnt = 0;
   bit hs_done_due = 0;
   bit zero_done_due = 0;
   bit prev_stall = 0;
   logic [DATA_W-1:0] prev_data;

   always #5 clk = ~clk;

   btop_rd_stream dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base     (base),
      .len      (len),
`ifdef BTOP_RD_REVERSE_EN
      .rev      (rev),
`endif
      .busy     (busy),
      .done     (done),
      .r_en     (r_en),
      .cntb     (cntb),
      .ram_dout (ram_dout),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_last   (m_last)
   );

   // RAM model: data one cycle after r_en, zero otherwise.
   always @(posedge clk) begin
      if (r_en) ram_dout <= ram[cntb[2:0]];
      else      ram_dout <= '0;
   end

   task automatic checki(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_data(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_msg(input string name, input int act);
      total++;
      bad++;
      $display("FAIL %s: got %0d expected nothing at %0t", name, act, $time);
   endtask

   // Monitor: compares every read issue, beat, done and stall on the negedge.
   initial begin
      bit exp_d;
      bit l;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall  = 0;
            hs_done_due = 0;
            issued      = acc;
         end else begin
            if (r_en) begin
               issued++;
               if (exp_addr.size() == 0) fail_msg("unexpected_read", int'(cntb));
               else checki("cntb", int'(cntb), int'(exp_addr.pop_front()));
            end
            if (prev_stall) begin
               checki("valid_held", int'(m_valid), 1);
               check_data("data_held", m_data, prev_data);
            end
            exp_d = hs_done_due | zero_done_due;
            hs_done_due = 0;
            checki("done", int'(done), int'(exp_d));
            if (done) done_cnt++;
            if (m_valid && m_ready) begin
               acc++;
               if (exp_data.size() == 0) begin
                  fail_msg("unexpected_beat", 1);
               end else begin
                  check_data("beat_data", m_data, exp_data.pop_front());
                  l = exp_last.pop_front();
                  checki("m_last", int'(m_last), int'(l));
                  if (l) hs_done_due = 1;
               end
            end
            checki("outstanding_le2", int'((issued - acc) <= 2), 1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
         end
      end
   end

   task automatic fill_ram();
      for (int i = 0; i < NCHUNK; i++)
         for (int j = 0; j < DATA_W / 32; j++)
            ram[i][j*32 +: 32] = $urandom;
   endtask

   function automatic logic ready_for(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (k % 3 == 0);
      return 1'($urandom_range(0, 1));
   endfunction

   // One burst: queue the expected reads/beats, start, and wait for done.
   task automatic run_burst(input int b, input int l, input int mode,
                            input bit r, input bit busy_start);
      int a, acc0, d0;
      bit seen;
      fill_ram();
      for (int i = 0; i < l; i++) begin
         a = r ? (((b - i) % NCHUNK) + NCHUNK) % NCHUNK : (b + i) % NCHUNK;
         exp_addr.push_back(CNT_W'(a));
         exp_data.push_back(ram[a]);
         exp_last.push_back(i == l - 1);
      end
      acc0 = acc;
      d0   = done_cnt;
      seen = 0;
      @(posedge clk); #1;
      base    = CNT_W'(b);
      len     = CNT_W'(l);
      rev     = r;
      start   = 1'b1;
      m_ready = ready_for(mode, 0);
      for (int k = 1; k < 300; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            start = 1'b0;
            checki("busy_after_start", int'(busy), int'(l != 0));
            if (l == 0) zero_done_due = 1;
         end
         if (k == 2) zero_done_due = 0;
         if (busy_start && k == 4) begin
            start = 1'b1;
            base  = CNT_W'(3);
            len   = CNT_W'(5);
         end
         if (busy_start && k == 5) start = 1'b0;
         if (!seen && m_valid) begin
            seen = 1;
            checki("first_beat_latency", k, 3);
         end
         m_ready = ready_for(mode, k);
         if (done_cnt != d0) break;
      end
      m_ready = 1'b1;
      repeat (2) @(posedge clk);
      checki("done_count", done_cnt - d0, 1);
      checki("beat_count", acc - acc0, l);
      checki("first_valid_seen", int'(seen), int'(l != 0));
      checki("queue_empty", exp_addr.size() + exp_data.size(), 0);
   endtask

   task automatic check_reset_outputs();
      checki("rst_busy", int'(busy), 0);
      checki("rst_done", int'(done), 0);
      checki("rst_r_en", int'(r_en), 0);
      checki("rst_cntb", int'(cntb), 0);
      checki("rst_m_valid", int'(m_valid), 0);
      checki("rst_m_last", int'(m_last), 0);
      check_data("rst_m_data", m_data, '0);
   endtask

   initial begin
      int acc0, d0, b, l, md;
      rst = 1'b1; start = 1'b0; base = '0; len = '0; rev = 1'b0; m_ready = 1'b1;
      fill_ram();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      run_burst(0, 8, 0, 0, 0);
      run_burst(6, 4, 0, 0, 0);
      run_burst(0, 8, 1, 0, 0);
      run_burst(0, 0, 0, 0, 0);
      run_burst(0, 8, 0, 0, 1);
      run_burst(5, 8, 1, 0, 1);
      for (int t = 0; t < 20; t++) begin
         b  = $urandom_range(0, NCHUNK - 1);
         l  = $urandom_range(0, NCHUNK);
         md = $urandom_range(0, 2);
         run_burst(b, l, md, 0, 0);
      end
`ifdef BTOP_RD_REVERSE_EN
      run_burst(1, 3, 0, 1, 0);
      for (int t = 0; t < 8; t++) begin
         b  = $urandom_range(0, NCHUNK - 1);
         l  = $urandom_range(1, NCHUNK);
         md = $urandom_range(0, 2);
         run_burst(b, l, md, 1, 0);
      end
`endif

      // Reset in the middle of a burst after the third beat.
      fill_ram();
      for (int i = 0; i < 8; i++) begin
         exp_addr.push_back(CNT_W'(i));
         exp_data.push_back(ram[i]);
         exp_last.push_back(i == 7);
      end
      acc0 = acc;
      @(posedge clk); #1;
      base = '0; len = CNT_W'(8); rev = 1'b0; start = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 50 && (acc - acc0) < 3; k++) @(posedge clk);
      checki("beats_before_reset", int'((acc - acc0) >= 3), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      exp_addr.delete();
      exp_data.delete();
      exp_last.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      d0 = done_cnt;
      repeat (12) @(posedge clk);
      checki("no_done_after_reset", done_cnt - d0, 0);

      // Normal operation resumes after the abandoned burst.
      run_burst(2, 5, 2, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
